// File: rtl/ast_packet_arbiter_pkg.sv
// Shared types and the round-robin selection function used by the packet arbiter
// and by other multi-port blocks that need the same priority scan.
package ast_arb_package;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int MAX_SRC   = 16;
  localparam int MAX_PTR_W = 4;

  // First set index at or after ptr, wrapping mod n; returns ptr when req is empty.
  function automatic logic [MAX_PTR_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0]   req,
    input logic [MAX_PTR_W-1:0] ptr,
    input int                   n
  );
    logic [MAX_PTR_W-1:0] pick;
    int idx;
    pick = ptr;
    // Scan from the farthest offset down so the nearest requester is written last.
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && req[idx[MAX_PTR_W-1:0]]) pick = idx[MAX_PTR_W-1:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/ast_packet_arbiter_picker.sv
// Combinational round-robin priority picker: first requester at or after ptr.
module rr_priority_picker
  import ast_arb_package::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] ptr,
  output logic [$clog2(N_SRC)-1:0] pick,
  output logic                     any
);

  localparam int PTR_W = $clog2(N_SRC);

  assign pick = PTR_W'(rr_pick(MAX_SRC'(req), MAX_PTR_W'(ptr), N_SRC));
  assign any  = |req;

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging N_SRC Avalon-ST sources onto one sink;
// the grant is held from start-of-packet through the accepted end-of-packet beat.
module ast_packet_arbiter
  import ast_arb_package::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = $clog2(DATA_W/8) ? $clog2(DATA_W/8) : 1,
  parameter int CHANNEL_W = 10
) (
  input  logic                            clk_i,
  input  logic                            srst_i,
  input  logic [N_SRC-1:0][DATA_W-1:0]    ast_data_i,
  input  logic [N_SRC-1:0]                ast_startofpacket_i,
  input  logic [N_SRC-1:0]                ast_endofpacket_i,
  input  logic [N_SRC-1:0]                ast_valid_i,
  input  logic [N_SRC-1:0][EMPTY_W-1:0]   ast_empty_i,
  output logic [N_SRC-1:0]                ast_ready_o,
  output logic [DATA_W-1:0]               ast_data_o,
  output logic                            ast_startofpacket_o,
  output logic                            ast_endofpacket_o,
  output logic                            ast_valid_o,
  output logic [EMPTY_W-1:0]              ast_empty_o,
  output logic [CHANNEL_W-1:0]            ast_channel_o,
  input  logic                            ast_ready_i
);

  localparam int PTR_W = $clog2(N_SRC);

  arb_state_t       state;
  logic [PTR_W-1:0] gnt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] pick;
  logic [N_SRC-1:0] req;
  logic             any_req;
  logic             pkt_end;

  // Only a valid start-of-packet beat competes; mid-packet beats stay stalled.
  assign req = ast_valid_i & ast_startofpacket_i;

  rr_priority_picker #(.N_SRC(N_SRC)) u_picker (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (any_req)
  );

  assign pkt_end = (state == BUSY) && ast_valid_i[gnt] && ast_ready_i && ast_endofpacket_i[gnt];

  // NOTE: state registers use non-blocking assignment so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (pkt_end) begin
            state  <= IDLE;
            rr_ptr <= (gnt == PTR_W'(N_SRC - 1)) ? '0 : gnt + PTR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the branch, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    ast_ready_o         = '0;
    ast_valid_o         = 1'b0;
    ast_data_o          = '0;
    ast_startofpacket_o = 1'b0;
    ast_endofpacket_o   = 1'b0;
    ast_empty_o         = '0;
    ast_channel_o       = '0;
    if (state == BUSY) begin
      ast_ready_o[gnt]    = ast_ready_i;
      ast_valid_o         = ast_valid_i[gnt];
      ast_data_o          = ast_data_i[gnt];
      ast_startofpacket_o = ast_startofpacket_i[gnt];
      ast_endofpacket_o   = ast_endofpacket_i[gnt];
      ast_empty_o         = ast_empty_i[gnt];
      ast_channel_o       = CHANNEL_W'(gnt);
    end
  end

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Directed bench for ast_packet_arbiter: inputs driven and outputs sampled on the
// falling edge; expected beats are hand-scheduled per scenario.
module tb_ast_packet_arbiter;

  localparam int OW = 84;  // valid + ready[4] + sop + eop + channel[10] + data[64] + empty[3]

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [3:0][63:0] ast_data_i;
  logic [3:0]       ast_startofpacket_i;
  logic [3:0]       ast_endofpacket_i;
  logic [3:0]       ast_valid_i;
  logic [3:0][2:0]  ast_empty_i;
  logic [3:0]       ast_ready_o;
  logic [63:0]      ast_data_o;
  logic             ast_startofpacket_o;
  logic             ast_endofpacket_o;
  logic             ast_valid_o;
  logic [2:0]       ast_empty_o;
  logic [9:0]       ast_channel_o;
  logic             ast_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  ast_packet_arbiter dut (
    .clk_i               (clk_i),
    .srst_i              (srst_i),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Payload fields only matter while valid is high, so they are zeroed otherwise.
  function automatic logic [OW-1:0] exp_word(input logic v, input logic [3:0] r, input logic sop,
                                             input logic eop, input logic [9:0] ch,
                                             input logic [63:0] d, input logic [2:0] e);
    return v ? {v, r, sop, eop, ch, d, e} : {1'b0, r, 79'b0};
  endfunction

  function automatic logic [OW-1:0] obs_word();
    return ast_valid_o ? {ast_valid_o, ast_ready_o, ast_startofpacket_o, ast_endofpacket_o,
                          ast_channel_o, ast_data_o, ast_empty_o}
                       : {ast_valid_o, ast_ready_o, 79'b0};
  endfunction

  task automatic drive_src(input int s, input logic v, input logic sop, input logic eop,
                           input logic [63:0] d, input logic [2:0] e);
    ast_valid_i[s]         = v;
    ast_startofpacket_i[s] = sop;
    ast_endofpacket_i[s]   = eop;
    ast_data_i[s]          = d;
    ast_empty_i[s]         = e;
  endtask

  task automatic clear_inputs();
    ast_data_i          = '0;
    ast_startofpacket_i = '0;
    ast_endofpacket_i   = '0;
    ast_valid_i         = '0;
    ast_empty_i         = '0;
    ast_ready_i         = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    clear_inputs();
    srst_i = 1'b1;
    @(negedge clk_i);
    srst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] got, want;
    @(negedge clk_i);
    srst_i = 1'b1;
    for (int s = 0; s < 4; s++) drive_src(s, 1'b1, 1'b1, 1'b1, 64'(s), 3'd0);
    @(negedge clk_i);
    #1;
    got  = obs_word();
    want = exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 10'd0, 64'd0, 3'd0);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=%h", got, want);
    end
    n_checks++;
    if (ast_channel_o !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_channel got=%0d want=0", ast_channel_o);
    end
    srst_i = 1'b0;
    @(negedge clk_i);
    #1;
    got  = obs_word();
    want = exp_word(1'b1, 4'b0001, 1'b1, 1'b1, 10'd0, 64'd0, 3'd0);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_first_grant got=%h want=%h", got, want);
    end
  endtask

  task automatic test_single();
    logic [63:0] dat [3];
    logic [OW-1:0] got, want;
    int k;
    dat[0] = 64'h11; dat[1] = 64'h22; dat[2] = 64'h33;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      k = (i == 0) ? 0 : i - 1;
      if (i <= 3) drive_src(2, 1'b1, k == 0, k == 2, dat[k], (k == 2) ? 3'd5 : 3'd0);
      else        drive_src(2, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
      #1;
      got = obs_word();
      if (i == 0 || i == 4) want = exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 10'd0, 64'd0, 3'd0);
      else want = exp_word(1'b1, 4'b0100, k == 0, k == 2, 10'd2, dat[k], (k == 2) ? 3'd5 : 3'd0);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single c%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_round_robin();
    int pkt [4];
    int bidx [4];
    int ph, g;
    logic [OW-1:0] got, want;
    do_reset();
    for (int s = 0; s < 4; s++) begin pkt[s] = 0; bidx[s] = 0; end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_i);
      for (int s = 0; s < 4; s++)
        drive_src(s, 1'b1, bidx[s] == 0, bidx[s] == 1, 64'(s * 65536 + pkt[s] * 256 + bidx[s]), 3'(s));
      #1;
      ph = c % 3;
      g  = (c / 3) % 4;
      got = obs_word();
      if (ph == 0) want = exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 10'd0, 64'd0, 3'd0);
      else want = exp_word(1'b1, 4'(1 << g), ph == 1, ph == 2, 10'(g),
                           64'(g * 65536 + pkt[g] * 256 + (ph - 1)), (ph == 2) ? 3'(g) : 3'(g));
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL round_robin c%0d got=%h want=%h", c, got, want);
      end
      if (ph != 0) begin
        bidx[g]++;
        if (bidx[g] == 2) begin bidx[g] = 0; pkt[g]++; end
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [OW-1:0] got, want;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      if (i <= 3) drive_src(1, 1'b1, i <= 1, i == 3, 64'h10 + 64'((i == 0) ? 0 : i - 1),
                            (i == 3) ? 3'd4 : 3'd0);
      else        drive_src(1, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
      if (i >= 1 && i <= 5) drive_src(0, 1'b1, 1'b1, 1'b1, 64'hF0, 3'd7);
      else                  drive_src(0, 1'b0, 1'b0, 1'b0, 64'd0, 3'd0);
      #1;
      got = obs_word();
      case (i)
        1:       want = exp_word(1'b1, 4'b0010, 1'b1, 1'b0, 10'd1, 64'h10, 3'd0);
        2:       want = exp_word(1'b1, 4'b0010, 1'b0, 1'b0, 10'd1, 64'h11, 3'd0);
        3:       want = exp_word(1'b1, 4'b0010, 1'b0, 1'b1, 10'd1, 64'h12, 3'd4);
        5:       want = exp_word(1'b1, 4'b0001, 1'b1, 1'b1, 10'd0, 64'hF0, 3'd7);
        default: want = exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 10'd0, 64'd0, 3'd0);
      endcase
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL no_preempt c%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    logic rdy [8];
    logic busy;
    int b;
    logic [OW-1:0] got, want;
    rdy[0] = 0; rdy[1] = 1; rdy[2] = 0; rdy[3] = 0;
    rdy[4] = 1; rdy[5] = 1; rdy[6] = 1; rdy[7] = 1;
    do_reset();
    b = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      ast_ready_i = rdy[i];
      drive_src(3, b < 4, b == 0, b == 3, 64'hA0 + 64'(b), (b == 3) ? 3'd2 : 3'd0);
      #1;
      busy = (i >= 1) && (b < 4);
      got  = obs_word();
      want = exp_word(busy, busy ? {rdy[i], 3'b000} : 4'b0000, b == 0, b == 3, 10'd3,
                      64'hA0 + 64'(b), (b == 3) ? 3'd2 : 3'd0);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL backpressure c%0d got=%h want=%h", i, got, want);
      end
      if (busy && rdy[i]) b++;
    end
    ast_ready_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    int pkt;
    logic [OW-1:0] got, want;
    do_reset();
    pkt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      drive_src(3, 1'b1, 1'b1, 1'b1, 64'(pkt), 3'd1);
      #1;
      got = obs_word();
      if (i % 2 == 0) want = exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 10'd0, 64'd0, 3'd0);
      else            want = exp_word(1'b1, 4'b1000, 1'b1, 1'b1, 10'd3, 64'(pkt), 3'd1);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back c%0d got=%h want=%h", i, got, want);
      end
      if (i % 2 == 1) pkt++;
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [OW-1:0] got, want;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      clear_inputs();
      srst_i = (i == 4);
      case (i)
        0, 1: drive_src(1, 1'b1, 1'b1, 1'b1, 64'h55, 3'd0);
        2, 3: drive_src(2, 1'b1, 1'b1, 1'b0, 64'h60, 3'd0);
        4:    drive_src(2, 1'b1, 1'b0, 1'b0, 64'h61, 3'd0);
        default:
          for (int s = 0; s < 4; s++) drive_src(s, 1'b1, 1'b1, 1'b1, 64'h70 + 64'(s), 3'd0);
      endcase
      #1;
      got = obs_word();
      case (i)
        1:       want = exp_word(1'b1, 4'b0010, 1'b1, 1'b1, 10'd1, 64'h55, 3'd0);
        3:       want = exp_word(1'b1, 4'b0100, 1'b1, 1'b0, 10'd2, 64'h60, 3'd0);
        4:       want = exp_word(1'b1, 4'b0100, 1'b0, 1'b0, 10'd2, 64'h61, 3'd0);
        6:       want = exp_word(1'b1, 4'b0001, 1'b1, 1'b1, 10'd0, 64'h70, 3'd0);
        default: want = exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 10'd0, 64'd0, 3'd0);
      endcase
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid_packet c%0d got=%h want=%h", i, got, want);
      end
    end
    srst_i = 1'b0;
  endtask

  initial begin
    srst_i = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
